// File: rtl/vc_buffer_if.sv
// Bus bundle between a router input port/allocator and one VC buffer.
// The slave side is the buffer. The master side is whatever feeds flits and
// consumes the head flit.
interface vc_buffer_if #(
  parameter int FLIT_W = 34
);
  logic [FLIT_W-1:0] flit;
  logic              load;
  logic              send;
  logic              next_router_credit;
  logic [FLIT_W-1:0] flit_buff;
  logic              valid;
  logic              credit;
  logic [4:0]        count;
  logic [3:0]        ds_count;
  logic              vc_free;
  logic              err;

  modport master (
    output flit, load, send, next_router_credit,
    input  flit_buff, valid, credit, count, ds_count, vc_free, err
  );

  modport slave (
    input  flit, load, send, next_router_credit,
    output flit_buff, valid, credit, count, ds_count, vc_free, err
  );
endinterface

// File: rtl/vc_buffer.sv
// Multi-flit virtual-channel buffer.
// - FIFO of DEPTH flits with head/tail packet framing.
// - Counts downstream credits.
// - Returns one upstream credit per dequeued flit after CREDIT_DELAY edges.
module vc_buffer #(
  parameter int FLIT_W       = 34,
  parameter int DEPTH        = 4,
  parameter int DS_CREDITS   = 4,
  parameter int CREDIT_DELAY = 2
) (
  input  logic       clock,
  input  logic       reset,
  vc_buffer_if.slave bus
);
  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [4:0]     DEPTH_C  = 5'(DEPTH);
  localparam logic [3:0]     DS_MAX   = 4'(DS_CREDITS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state, state_next;
  logic [FLIT_W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [4:0]              count;
  logic [3:0]              ds_count;
  logic [CREDIT_DELAY-1:0] delay_line;
  logic                    credit;
  logic                    err;
  logic                    valid, send_ok, load_ok, head, tail, frame_err, err_set;

  assign head    = bus.flit[FLIT_W-1];
  assign tail    = bus.flit[FLIT_W-2];
  assign valid   = (count != 5'd0) && (ds_count != 4'd0);
  assign send_ok = bus.send && valid;
  // A full FIFO still accepts a flit when a slot is freed on the same edge.
  assign load_ok = bus.load && ((count < DEPTH_C) || send_ok);
  assign err_set = frame_err
                 || (bus.load && !load_ok)
                 || (bus.next_router_credit && (ds_count == DS_MAX))
                 || (bus.send && !valid);

  // Framing state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Framing next state. Only accepted loads move the FSM.
  // Protocol violations are flagged, but the flit is still stored.
  always_comb begin
    state_next = state;
    frame_err  = 1'b0;
    if (load_ok) begin
      case (state)
        IDLE: begin
          if (head && !tail) state_next = ACTIVE;
          if (!head)         frame_err  = 1'b1;
        end
        ACTIVE: begin
          if (tail) state_next = IDLE;
          if (head) frame_err  = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Flit storage and write pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (load_ok) begin
      mem[wr_ptr] <= bus.flit;
      wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on every accepted dequeue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        rd_ptr <= '0;
    else if (send_ok) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
  end

  // Occupancy count. A simultaneous load and send leaves it unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= '0;
    else begin
      case ({load_ok, send_ok})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Downstream credits. A spurious return at the maximum saturates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ds_count <= DS_MAX;
    else begin
      case ({bus.next_router_credit, send_ok})
        2'b10:   ds_count <= (ds_count == DS_MAX) ? ds_count : ds_count + 4'd1;
        2'b01:   ds_count <= ds_count - 4'd1;
        default: ds_count <= ds_count;
      endcase
    end
  end

  // Credit delay line.
  // - A token enters on the dequeue edge.
  // - The output register makes the pulse visible CREDIT_DELAY edges later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delay_line <= '0;
      credit     <= 1'b0;
    end else begin
      delay_line <= (delay_line << 1) | CREDIT_DELAY'(send_ok);
      credit     <= delay_line[CREDIT_DELAY-1];
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  assign bus.flit_buff = mem[rd_ptr];
  assign bus.valid     = valid;
  assign bus.credit    = credit;
  assign bus.count     = count;
  assign bus.ds_count  = ds_count;
  assign bus.vc_free   = (state == IDLE) && (count == 5'd0);
  assign bus.err       = err;
endmodule

// File: tb/tb_vc_buffer.sv
// Directed bench for vc_buffer.
// Three instances are used: the default configuration, DS_CREDITS=1, and DEPTH=3.
module tb_vc_buffer;
  localparam int W = 34;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vc_buffer_if #(.FLIT_W(W)) ia ();
  vc_buffer_if #(.FLIT_W(W)) ib ();
  vc_buffer_if #(.FLIT_W(W)) ic ();

  vc_buffer #(.FLIT_W(W)) dut_a (.clock(clock), .reset(reset), .bus(ia));
  vc_buffer #(.FLIT_W(W), .DS_CREDITS(1)) dut_b (.clock(clock), .reset(reset), .bus(ib));
  vc_buffer #(.FLIT_W(W), .DEPTH(3)) dut_c (.clock(clock), .reset(reset), .bus(ic));

  int vec_count  = 0;
  int miss_count = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("  ok %s = %0h", tag, got);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic h, input logic t, input logic [31:0] p);
    return {h, t, p};
  endfunction

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    ia.flit = '0; ia.load = 1'b0; ia.send = 1'b0; ia.next_router_credit = 1'b0;
    ib.flit = '0; ib.load = 1'b0; ib.send = 1'b0; ib.next_router_credit = 1'b0;
    ic.flit = '0; ic.load = 1'b0; ic.send = 1'b0; ic.next_router_credit = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step;
    step;
    reset = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    step;
    step;
    reset = 1'b0;

    // Reset state of the default instance.
    check("rst_count",   64'(ia.count),     64'd0);
    check("rst_ds",      64'(ia.ds_count),  64'd4);
    check("rst_vc_free", 64'(ia.vc_free),   64'd1);
    check("rst_credit",  64'(ia.credit),    64'd0);
    check("rst_err",     64'(ia.err),       64'd0);
    check("rst_buff",    64'(ia.flit_buff), 64'd0);
    check("rst_valid",   64'(ia.valid),     64'd0);

    // Load a head/body/tail packet, then send it on three consecutive cycles.
    ia.load = 1'b1; ia.flit = mk(1, 0, 32'hA1);
    step;
    check("pkt_count1", 64'(ia.count),     64'd1);
    check("pkt_valid1", 64'(ia.valid),     64'd1);
    check("pkt_buff1",  64'(ia.flit_buff), 64'(mk(1, 0, 32'hA1)));
    check("pkt_free1",  64'(ia.vc_free),   64'd0);
    ia.flit = mk(0, 0, 32'hA2);
    step;
    ia.flit = mk(0, 1, 32'hA3);
    step;
    check("pkt_count3", 64'(ia.count), 64'd3);
    ia.load = 1'b0; ia.send = 1'b1;
    check("pkt_out0", 64'(ia.flit_buff), 64'(mk(1, 0, 32'hA1)));
    step;
    check("pkt_out1", 64'(ia.flit_buff), 64'(mk(0, 0, 32'hA2)));
    check("pkt_ds3",  64'(ia.ds_count),  64'd3);
    check("pkt_cr_e4", 64'(ia.credit),   64'd0);
    step;
    check("pkt_out2", 64'(ia.flit_buff), 64'(mk(0, 1, 32'hA3)));
    check("pkt_ds2",  64'(ia.ds_count),  64'd2);
    check("pkt_cr_e5", 64'(ia.credit),   64'd0);
    step;
    ia.send = 1'b0;
    check("pkt_count0", 64'(ia.count),   64'd0);
    check("pkt_ds1",    64'(ia.ds_count), 64'd1);
    check("pkt_free",   64'(ia.vc_free), 64'd1);
    check("pkt_cr_1",   64'(ia.credit),  64'd1);
    step;
    check("pkt_cr_2",   64'(ia.credit),  64'd1);
    step;
    check("pkt_cr_3",   64'(ia.credit),  64'd1);
    step;
    check("pkt_cr_off", 64'(ia.credit),  64'd0);
    check("pkt_err",    64'(ia.err),     64'd0);

    // Downstream returns three credits.
    ia.next_router_credit = 1'b1;
    step;
    step;
    step;
    ia.next_router_credit = 1'b0;
    check("ret_ds4",  64'(ia.ds_count), 64'd4);
    check("ret_err",  64'(ia.err),      64'd0);

    // Fill all four entries, then overflow with a fifth load.
    ia.load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ia.flit = mk(1, 1, 32'(32'h10 + i));
      step;
    end
    check("full_count", 64'(ia.count), 64'd4);
    ia.flit = mk(1, 1, 32'h14);
    step;
    ia.load = 1'b0;
    check("ovf_count", 64'(ia.count),     64'd4);
    check("ovf_err",   64'(ia.err),       64'd1);
    check("ovf_buff",  64'(ia.flit_buff), 64'(mk(1, 1, 32'h10)));
    do_reset();
    check("ovf_err_clr", 64'(ia.err), 64'd0);

    // Fill again; the fifth load coincides with a send and is accepted.
    ia.load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ia.flit = mk(1, 1, 32'(32'h20 + i));
      step;
    end
    ia.flit = mk(1, 1, 32'h24); ia.send = 1'b1;
    step;
    ia.load = 1'b0;
    check("cc_count", 64'(ia.count),     64'd4);
    check("cc_err",   64'(ia.err),       64'd0);
    check("cc_buff1", 64'(ia.flit_buff), 64'(mk(1, 1, 32'h21)));
    check("cc_ds3",   64'(ia.ds_count),  64'd3);
    step;
    check("cc_buff2", 64'(ia.flit_buff), 64'(mk(1, 1, 32'h22)));
    step;
    check("cc_buff3", 64'(ia.flit_buff), 64'(mk(1, 1, 32'h23)));
    step;
    check("cc_buff4", 64'(ia.flit_buff), 64'(mk(1, 1, 32'h24)));
    check("cc_ds0",    64'(ia.ds_count), 64'd0);
    check("cc_valid0", 64'(ia.valid),    64'd0);
    check("cc_count1", 64'(ia.count),    64'd1);
    step;
    ia.send = 1'b0;
    check("cc_bad_send_err", 64'(ia.err),   64'd1);
    check("cc_bad_send_cnt", 64'(ia.count), 64'd1);
    do_reset();

    // Framing: a body flit while IDLE is an error but is still stored.
    ia.load = 1'b1; ia.flit = mk(0, 0, 32'h55);
    step;
    ia.load = 1'b0;
    check("frm_body_err", 64'(ia.err),   64'd1);
    check("frm_body_cnt", 64'(ia.count), 64'd1);
    do_reset();

    // Framing: a single-flit packet keeps the FSM IDLE.
    ia.load = 1'b1; ia.flit = mk(1, 1, 32'h66);
    step;
    ia.load = 1'b0; ia.send = 1'b1;
    check("frm_single_free0", 64'(ia.vc_free), 64'd0);
    step;
    ia.send = 1'b0;
    check("frm_single_free1", 64'(ia.vc_free), 64'd1);
    check("frm_single_err",   64'(ia.err),     64'd0);

    // Framing: a head-only packet leaves the FSM ACTIVE after draining.
    ia.load = 1'b1; ia.flit = mk(1, 0, 32'h77);
    step;
    ia.load = 1'b0; ia.send = 1'b1;
    step;
    ia.send = 1'b0;
    check("frm_head_cnt",  64'(ia.count),   64'd0);
    check("frm_head_free", 64'(ia.vc_free), 64'd0);
    ia.load = 1'b1; ia.flit = mk(0, 0, 32'h78);
    step;
    ia.load = 1'b0;

    // Reset mid-packet: outputs return to reset values asynchronously.
    // The pending credit token is discarded.
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_count", 64'(ia.count),     64'd0);
    check("mid_rst_ds",    64'(ia.ds_count),  64'd4);
    check("mid_rst_free",  64'(ia.vc_free),   64'd1);
    check("mid_rst_valid", 64'(ia.valid),     64'd0);
    check("mid_rst_buff",  64'(ia.flit_buff), 64'd0);
    check("mid_rst_err",   64'(ia.err),       64'd0);
    reset = 1'b0;
    step;
    check("mid_rst_credit", 64'(ia.credit), 64'd0);

    // DS_CREDITS=1: the second send must wait for a downstream credit.
    check("b_rst_ds", 64'(ib.ds_count), 64'd1);
    ib.load = 1'b1; ib.flit = mk(1, 1, 32'hB0);
    step;
    ib.flit = mk(1, 1, 32'hB1);
    step;
    ib.load = 1'b0; ib.send = 1'b1;
    step;
    ib.send = 1'b0;
    check("b_count1", 64'(ib.count),     64'd1);
    check("b_ds0",    64'(ib.ds_count),  64'd0);
    check("b_valid0", 64'(ib.valid),     64'd0);
    check("b_buff",   64'(ib.flit_buff), 64'(mk(1, 1, 32'hB1)));
    ib.next_router_credit = 1'b1;
    step;
    ib.next_router_credit = 1'b0;
    check("b_valid1", 64'(ib.valid), 64'd1);
    ib.send = 1'b1;
    step;
    ib.send = 1'b0;
    check("b_count0", 64'(ib.count),    64'd0);
    check("b_ds_end", 64'(ib.ds_count), 64'd0);
    check("b_err",    64'(ib.err),      64'd0);

    // DEPTH=3: seven flits stream through, so both pointers wrap twice.
    for (int k = 1; k <= 8; k++) begin
      ic.load = (k <= 7);
      ic.flit = mk(1, 1, 32'(32'h100 + k - 1));
      ic.send = (k >= 2);
      ic.next_router_credit = (k >= 3);
      step;
      if (k <= 7) begin
        check($sformatf("c_buff%0d", k), 64'(ic.flit_buff), 64'(mk(1, 1, 32'(32'h100 + k - 1))));
        check($sformatf("c_count%0d", k), 64'(ic.count), 64'd1);
      end
    end
    idle_inputs();
    check("c_count_end", 64'(ic.count),    64'd0);
    check("c_ds_end",    64'(ic.ds_count), 64'd3);
    check("c_err",       64'(ic.err),      64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end
endmodule

// File: doc/vc_buffer.md
# vc_buffer

Parametrised multi-flit virtual-channel buffer with credit-based flow control toward the downstream router and delayed per-flit credit return toward the upstream router. It replaces the single-flit, single-credit VC. It holds up to DEPTH flits, tracks packet framing from head/tail bits, and counts downstream credits. It sits between a router input port and the switch allocator/crossbar, one instance per VC.

## Interface
- FLIT_W, 34: flit width in bits.
  - Bit FLIT_W-1 = head.
  - Bit FLIT_W-2 = tail.
  - Both set = single-flit packet.
- DEPTH, 4: FIFO entries, 2..16. Not required to be a power of two.
- DS_CREDITS, 4: initial and maximum downstream credit count, 1..15.
- CREDIT_DELAY, 2: cycles from dequeue to credit_out pulse, 1..8.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- flit  in  FLIT_W  incoming flit.
- load  in  1  write strobe for flit.
- send  in  1  allocator takes the head flit this cycle. Ignored unless valid is high.
- next_router_credit  in  1  one-credit return pulse from downstream.
- flit_buff  out  FLIT_W  head-of-FIFO flit (combinational from storage).
- valid  out  1  count>0 and ds_count>0 (combinational).
- credit  out  1  one-cycle pulse returning one slot upstream.
- count  out  5  flits held.
- ds_count  out  4  downstream credits available.
- vc_free  out  1  input FSM IDLE and count==0.
- err  out  1  sticky protocol/overflow error.

## Operation
- Enqueue: on load with count<DEPTH, or count==DEPTH with send accepted the same cycle:
  - write mem[wr_ptr];
  - wr_ptr wraps DEPTH-1 -> 0.
- Dequeue: on send && valid:
  - rd_ptr advances with the same wrap;
  - ds_count decrements;
  - a token enters the credit delay line.
- count arithmetic per cycle:
  - +1 on accepted load only;
  - -1 on accepted send only;
  - unchanged when both occur.
- ds_count arithmetic per cycle:
  - +1 on next_router_credit only;
  - -1 on accepted send only;
  - unchanged when both occur.
- Credit delay line: CREDIT_DELAY-stage shift register. A token inserted at edge N produces credit=1 during cycle N+CREDIT_DELAY. Back-to-back dequeues give back-to-back pulses.
- Input framing FSM, states IDLE and ACTIVE, updated on accepted loads only:
  - IDLE + head without tail -> ACTIVE.
  - IDLE + head with tail -> IDLE.
  - ACTIVE + tail -> IDLE.
  - ACTIVE + body -> ACTIVE.
- Framing errors (flit is still stored, FSM follows the rules above, err set):
  - ACTIVE + head: FSM stays ACTIVE, or goes IDLE if the tail bit is also set.
  - IDLE + non-head flit: FSM stays IDLE.
- err also sets on any of:
  - load rejected because the FIFO is full (flit dropped, nothing changes);
  - next_router_credit while ds_count==DS_CREDITS (ds_count saturates);
  - send while valid==0 (ignored).
- err clears only on reset.

## Timing
- Reset values:
  - count=0, ds_count=DS_CREDITS, pointers=0, all mem entries 0;
  - flit_buff=0, valid=0, credit=0, err=0;
  - FSM IDLE, vc_free=1, delay line cleared.
- Load-to-valid latency: 1 cycle. A load at edge N gives valid=1 after N if ds_count>0.
- Credit latency: a send at edge N gives credit high for exactly one cycle after edge N+CREDIT_DELAY.
- flit_buff changes to the next entry immediately after the dequeue edge.
- Reset mid-operation: all state returns to reset values asynchronously. Pending credit tokens are discarded; upstream also resets.
- Sustained throughput: 1 flit/cycle in and out, given credits available.

## Test plan
- Reset then idle:
  - count=0, ds_count=4, vc_free=1, credit=0, err=0, flit_buff=0.
- Load head / body / tail packet (3 flits), send on 3 consecutive cycles, with DS_CREDITS=4:
  - flits exit in order;
  - ds_count 4->1;
  - credit pulses at cycles send+2, +3, +4;
  - vc_free=1 after the last dequeue.
- Fill 4 flits, then load a 5th:
  - 5th flit dropped, err=1, count stays 4.
- Repeat with the 5th load concurrent with a send:
  - accepted, count stays 4, err=0.
- DS_CREDITS=1, 2 flits buffered:
  - first send accepted, then valid=0;
  - next_router_credit pulse -> valid=1 next cycle;
  - second send accepted.
- DEPTH=3 wrap:
  - 7 load/send pairs stream through with correct order and pointer wrap.
- Framing:
  - body flit in IDLE -> err=1;
  - single-flit packet (head+tail) -> FSM stays IDLE;
  - reset asserted mid-packet -> all outputs at reset values within the same cycle.
